// File: rtl/ux607_mrom_ctrl.sv
// Dual-port read-only front end for ux607_mrom; round-robin arbitration when UX607_MROM_CTRL_RR_EN is defined, else port 0 wins.
// Latency: command handshake to rsp_valid in exactly 1 cycle; one response buffered for the granted port.
// Backpressure: while the owner holds rsp_ready low, no command is accepted on either port.
module ux607_mrom_ctrl #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          i0_cmd_valid,
  output logic          i0_cmd_ready,
  input  logic [AW-1:0] i0_cmd_addr,
  input  logic          i0_cmd_read,
  output logic          i0_rsp_valid,
  input  logic          i0_rsp_ready,
  output logic [DW-1:0] i0_rsp_rdata,
  output logic          i0_rsp_err,

  input  logic          i1_cmd_valid,
  output logic          i1_cmd_ready,
  input  logic [AW-1:0] i1_cmd_addr,
  input  logic          i1_cmd_read,
  output logic          i1_rsp_valid,
  input  logic          i1_rsp_ready,
  output logic [DW-1:0] i1_rsp_rdata,
  output logic          i1_rsp_err,

  output logic [AW-3:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  state_t        state_q;
  state_t        state_d;
  logic          owner_q;
  rsp_t          rsp_q;
  rsp_t          rsp_d;

  logic          owner_rdy;
  logic          accept_ok;
  logic          prio0;
  logic          grant0;
  logic          grant1;
  logic          grant_any;
  logic [AW-1:0] sel_addr;
  logic          sel_read;

`ifdef UX607_MROM_CTRL_RR_EN
  // Pointer flips to the other port after every grant so it wins the next tie.
  logic rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (grant0) begin
      rr_ptr_q <= 1'b1;
    end else if (grant1) begin
      rr_ptr_q <= 1'b0;
    end
  end

  assign prio0 = ~rr_ptr_q;
`else
  assign prio0 = 1'b1;
`endif

  assign owner_rdy = owner_q ? i1_rsp_ready : i0_rsp_ready;
  assign grant_any = grant0 | grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept_ok = 1'b0;
    case (state_q)
      IDLE: accept_ok = 1'b1;
      RSP:  accept_ok = owner_rdy;
      default: accept_ok = 1'b0;
    endcase

    // Grants look only at the requesters' valids, never at our own ready outputs.
    grant0 = accept_ok & i0_cmd_valid & (prio0 | ~i1_cmd_valid);
    grant1 = accept_ok & i1_cmd_valid & (~prio0 | ~i0_cmd_valid);

    case (state_q)
      IDLE: if (grant0 | grant1) state_d = RSP;
      RSP:  if (owner_rdy && !(grant0 | grant1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_addr  = grant1 ? i1_cmd_addr : i0_cmd_addr;
  assign sel_read  = grant1 ? i1_cmd_read : i0_cmd_read;
  assign rom_addr  = sel_addr[AW-1:2];

  // Writes and misaligned reads are answered with an error and zero data.
  always_comb begin
    rsp_d.err   = ~sel_read | (sel_addr[1:0] != 2'b00);
    rsp_d.rdata = rsp_d.err ? '0 : rom_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q   <= '0;
      owner_q <= 1'b0;
    end else if (grant_any) begin
      rsp_q   <= rsp_d;
      owner_q <= grant1;
    end
  end

  assign i0_cmd_ready = grant0;
  assign i1_cmd_ready = grant1;

  assign i0_rsp_valid = (state_q == RSP) & ~owner_q;
  assign i1_rsp_valid = (state_q == RSP) &  owner_q;

  assign i0_rsp_rdata = owner_q ? '0 : rsp_q.rdata;
  assign i0_rsp_err   = ~owner_q & rsp_q.err;
  assign i1_rsp_rdata = owner_q ? rsp_q.rdata : '0;
  assign i1_rsp_err   = owner_q & rsp_q.err;

endmodule

// File: tb/tb_ux607_mrom_ctrl.sv
// Scoreboard bench for ux607_mrom_ctrl with a small behavioural ROM image.
module tb_ux607_mrom_ctrl;

  logic             clk;
  logic             rst;
  logic [1:0]       cmd_valid;
  logic [1:0]       cmd_ready;
  logic [1:0]       cmd_read;
  logic [1:0][11:0] cmd_addr;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;
  logic [9:0]       rom_addr;
  logic [31:0]      rom_dout;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          p;
    logic [11:0] a;
    logic        rd;
    logic        err;
    logic [31:0] d;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hs_cyc[2];

  ux607_mrom_ctrl #(.AW(12), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i0_cmd_valid (cmd_valid[0]),
    .i0_cmd_ready (cmd_ready[0]),
    .i0_cmd_addr  (cmd_addr[0]),
    .i0_cmd_read  (cmd_read[0]),
    .i0_rsp_valid (rsp_valid[0]),
    .i0_rsp_ready (rsp_ready[0]),
    .i0_rsp_rdata (rsp_rdata[0]),
    .i0_rsp_err   (rsp_err[0]),
    .i1_cmd_valid (cmd_valid[1]),
    .i1_cmd_ready (cmd_ready[1]),
    .i1_cmd_addr  (cmd_addr[1]),
    .i1_cmd_read  (cmd_read[1]),
    .i1_rsp_valid (rsp_valid[1]),
    .i1_rsp_ready (rsp_ready[1]),
    .i1_rsp_rdata (rsp_rdata[1]),
    .i1_rsp_err   (rsp_err[1]),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout)
  );

  always_comb begin
    case (rom_addr)
      10'd0:   rom_dout = 32'h7ffff297;
      10'd1:   rom_dout = 32'h00028067;
      10'd2:   rom_dout = 32'h00000000;
      default: rom_dout = 32'hdead0000 | {22'd0, rom_addr};
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input int p, input exp_t e);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp port%0d: actual=%h required=none", p, {rsp_err[p], rsp_rdata[p]});
          end else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("rsp_port%0d", p), 64'({rsp_err[p], rsp_rdata[p]}), 64'(e));
          end
        end
      end
    end
  end

  task automatic do_cmd(input int p, input logic [11:0] a, input logic rd, input exp_t e);
    bit got;
    got = 1'b0;
    cmd_valid[p] = 1'b1;
    cmd_addr[p]  = a;
    cmd_read[p]  = rd;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready[p]) begin
        push(p, e);
        hs_cyc[p] = cyc;
        got = 1'b1;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL cmd_timeout port%0d: actual=no_ready required=ready", p);
    end
    @(posedge clk); #1;
    cmd_valid[p] = 1'b0;
    if (got) begin
      @(negedge clk);
      chk($sformatf("latency_port%0d", p), 64'(rsp_valid[p]), 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  vec_t vt[9] = '{
    '{0, 12'h000, 1'b1, 1'b0, 32'h7ffff297},
    '{0, 12'h002, 1'b1, 1'b1, 32'h00000000},
    '{1, 12'h008, 1'b0, 1'b1, 32'h00000000},
    '{1, 12'h008, 1'b1, 1'b0, 32'h00000000},
    '{1, 12'h004, 1'b1, 1'b0, 32'h00028067},
    '{0, 12'h00c, 1'b0, 1'b1, 32'h00000000},
    '{1, 12'h014, 1'b1, 1'b0, 32'hdead0005},
    '{1, 12'h001, 1'b1, 1'b1, 32'h00000000},
    '{0, 12'h010, 1'b1, 1'b0, 32'hdead0004}
  };

  initial begin
    exp_t e;
    int   last;
    rst       = 1'b1;
    cmd_valid = 2'b00;
    cmd_read  = 2'b00;
    cmd_addr  = '0;
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_rdata0",    64'(rsp_rdata[0]), 64'd0);
    chk("rst_rdata1",    64'(rsp_rdata[1]), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;

    last = -1;
    foreach (vt[i]) begin
      e.err   = vt[i].err;
      e.rdata = vt[i].d;
      do_cmd(vt[i].p, vt[i].a, vt[i].rd, e);
      chk($sformatf("hs_order_%0d", i), 64'(hs_cyc[vt[i].p] > last), 64'd1);
      last = hs_cyc[vt[i].p];
    end

    // Simultaneous requests from both ports.
    do_reset();
`ifdef UX607_MROM_CTRL_RR_EN
    fork
      do_cmd(0, 12'h000, 1'b1, exp_t'({1'b0, 32'h7ffff297}));
      do_cmd(1, 12'h004, 1'b1, exp_t'({1'b0, 32'h00028067}));
    join
    chk("rr_i1_next_cycle", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
`else
    cmd_addr[0]  = 12'h000;
    cmd_read[0]  = 1'b1;
    cmd_addr[1]  = 12'h004;
    cmd_read[1]  = 1'b1;
    cmd_valid    = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fixed_i1_blocked", 64'(cmd_ready[1]), 64'd0);
      chk("fixed_i0_grant",   64'(cmd_ready[0]), 64'd1);
      if (cmd_ready[0]) push(0, exp_t'({1'b0, 32'h7ffff297}));
      @(posedge clk); #1;
    end
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("fixed_i1_grant", 64'(cmd_ready[1]), 64'd1);
    if (cmd_ready[1]) push(1, exp_t'({1'b0, 32'h00028067}));
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    chk("fixed_i1_rsp_valid", 64'(rsp_valid[1]), 64'd1);
    @(posedge clk); #1;
`endif

    // Owner stalls its response while the other port waits.
    do_reset();
    rsp_ready[0] = 1'b0;
    do_cmd(0, 12'h004, 1'b1, exp_t'({1'b0, 32'h00028067}));
    cmd_addr[1]  = 12'h000;
    cmd_read[1]  = 1'b1;
    cmd_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rdata",      64'(rsp_rdata[0]), 64'h00028067);
      chk("hold_valid",      64'(rsp_valid[0]), 64'd1);
      chk("hold_i1_blocked", 64'(cmd_ready[1]), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("release_i1_grant", 64'(cmd_ready[1]), 64'd1);
    if (cmd_ready[1]) push(1, exp_t'({1'b0, 32'h7ffff297}));
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    chk("release_i1_valid", 64'(rsp_valid[1]), 64'd1);
    @(posedge clk); #1;

    // Reset while a response is held.
    rsp_ready[0] = 1'b0;
    do_cmd(0, 12'h000, 1'b1, exp_t'({1'b0, 32'h7ffff297}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("rst_rsp_dropped", 64'(rsp_valid), 64'd0);
    chk("rst_rdata_clear", 64'(rsp_rdata[0]), 64'd0);
    chk("rst_err_clear",   64'(rsp_err),   64'd0);
    @(posedge clk); #1;
    do_cmd(0, 12'h004, 1'b1, exp_t'({1'b0, 32'h00028067}));

    @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
